// File: rtl/host_regfile.sv
// host_regfile: host-visible control/status registers for the vector-adder
// accelerator. It decodes TSIM host read/write requests, holds the job
// parameters (length and the three base addresses), emits a one-cycle launch
// pulse, and records finish status and the cycle count from the memory stage.
//
// Ports
//   clock, reset          clock; synchronous active-high reset
//   host_req_*            host request (valid/opcode/addr/value), host_req_deq = accept
//   host_resp_valid/bits  read response, one cycle after accept
//   launch                one-cycle start pulse to the memory stage
//   finish                one-cycle completion from the memory stage
//   event_counter_*       cycle count returned by the memory stage
//   length, *_addr        live register contents read by the memory stage
module host_regfile #(
  parameter int HOST_ADDR_BITS = 8,
  parameter int HOST_DATA_BITS = 32
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      host_req_valid,
  input  logic                      host_req_opcode,
  input  logic [HOST_ADDR_BITS-1:0] host_req_addr,
  input  logic [HOST_DATA_BITS-1:0] host_req_value,
  output logic                      host_req_deq,
  output logic                      host_resp_valid,
  output logic [HOST_DATA_BITS-1:0] host_resp_bits,
  output logic                      launch,
  input  logic                      finish,
  input  logic                      event_counter_valid,
  input  logic [HOST_DATA_BITS-1:0] event_counter_value,
  output logic [HOST_DATA_BITS-1:0] length,
  output logic [HOST_DATA_BITS-1:0] a_addr,
  output logic [HOST_DATA_BITS-1:0] b_addr,
  output logic [HOST_DATA_BITS-1:0] c_addr
);

  localparam logic [HOST_ADDR_BITS-1:0] ADDR_CTRL   = HOST_ADDR_BITS'(8'h00);
  localparam logic [HOST_ADDR_BITS-1:0] ADDR_CYCLES = HOST_ADDR_BITS'(8'h04);
  localparam logic [HOST_ADDR_BITS-1:0] ADDR_LENGTH = HOST_ADDR_BITS'(8'h08);
  localparam logic [HOST_ADDR_BITS-1:0] ADDR_A      = HOST_ADDR_BITS'(8'h0C);
  localparam logic [HOST_ADDR_BITS-1:0] ADDR_B      = HOST_ADDR_BITS'(8'h10);
  localparam logic [HOST_ADDR_BITS-1:0] ADDR_C      = HOST_ADDR_BITS'(8'h14);

  typedef enum logic [1:0] {IDLE, READ, WRITE} state_t;

  state_t                    state;
  logic [HOST_ADDR_BITS-1:0] addr_q;
  logic [HOST_DATA_BITS-1:0] value_q;
  logic [HOST_DATA_BITS-1:0] cycles;
  logic                      finish_bit;
  logic                      busy;
  logic [HOST_DATA_BITS-1:0] rd_data;

  // Reset is synchronous, so gate the state-decoded handshakes with it: a
  // request caught mid-flight when reset rises gets neither accept nor response.
  assign host_req_deq    = (state == IDLE) && host_req_valid && !reset;
  assign host_resp_valid = (state == READ) && !reset;
  assign host_resp_bits  = host_resp_valid ? rd_data : '0;

  // Read mux sees register state at the start of the READ cycle, so a finish
  // landing in that same cycle shows up only on a later read.
  always_comb begin
    rd_data = '0;
    case (addr_q)
      ADDR_CTRL: begin
        rd_data[1] = finish_bit;
        rd_data[2] = busy;
      end
      ADDR_CYCLES: rd_data = cycles;
      ADDR_LENGTH: rd_data = length;
      ADDR_A:      rd_data = a_addr;
      ADDR_B:      rd_data = b_addr;
      ADDR_C:      rd_data = c_addr;
      default:     rd_data = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= IDLE;
      addr_q     <= '0;
      value_q    <= '0;
      cycles     <= '0;
      finish_bit <= 1'b0;
      busy       <= 1'b0;
      launch     <= 1'b0;
      length     <= '0;
      a_addr     <= '0;
      b_addr     <= '0;
      c_addr     <= '0;
    end else begin
      launch <= 1'b0;
      if (finish) begin
        finish_bit <= 1'b1;
        busy       <= 1'b0;
      end
      if (event_counter_valid) cycles <= event_counter_value;

      case (state)
        IDLE: begin
          if (host_req_valid) begin
            addr_q  <= host_req_addr;
            value_q <= host_req_value;
            state   <= host_req_opcode ? WRITE : READ;
          end
        end
        READ: state <= IDLE;
        WRITE: begin
          state <= IDLE;
          // Everything writable is frozen while a run is in progress: the
          // memory stage reads the parameters live.
          if (!busy) begin
            case (addr_q)
              ADDR_CTRL: begin
                if (value_q[0]) begin
                  busy       <= 1'b1;
                  finish_bit <= 1'b0;
                  cycles     <= '0;
                  launch     <= 1'b1;
                end
              end
              ADDR_LENGTH: length <= value_q;
              ADDR_A:      a_addr <= value_q;
              ADDR_B:      b_addr <= value_q;
              ADDR_C:      c_addr <= value_q;
              default: ;
            endcase
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_host_regfile.sv
// Directed bench for host_regfile: drives host requests on the falling edge
// and checks outputs against hand-computed values.
module tb_host_regfile;
  logic        clock = 1'b0;
  logic        reset;
  logic        host_req_valid, host_req_opcode;
  logic [7:0]  host_req_addr;
  logic [31:0] host_req_value;
  logic        host_req_deq, host_resp_valid;
  logic [31:0] host_resp_bits;
  logic        launch, finish, event_counter_valid;
  logic [31:0] event_counter_value;
  logic [31:0] length, a_addr, b_addr, c_addr;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  host_regfile #(.HOST_ADDR_BITS(8), .HOST_DATA_BITS(32)) dut (
    .clock(clock), .reset(reset),
    .host_req_valid(host_req_valid), .host_req_opcode(host_req_opcode),
    .host_req_addr(host_req_addr), .host_req_value(host_req_value),
    .host_req_deq(host_req_deq), .host_resp_valid(host_resp_valid),
    .host_resp_bits(host_resp_bits), .launch(launch), .finish(finish),
    .event_counter_valid(event_counter_valid),
    .event_counter_value(event_counter_value),
    .length(length), .a_addr(a_addr), .b_addr(b_addr), .c_addr(c_addr)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Presents a request on a falling edge (cycle T), checks accept, then
  // checks the T+1 response. Returns at the falling edge inside T+1.
  // fin_in_read pulses finish during the READ cycle.
  task automatic req(input logic op, input logic [7:0] addr, input logic [31:0] val,
                     input logic [31:0] exp_rd, input bit fin_in_read, input string tag);
    @(negedge clock);
    host_req_valid = 1'b1; host_req_opcode = op;
    host_req_addr = addr;  host_req_value = val;
    #1;
    chk({tag, ".deq"}, 32'(host_req_deq), 32'd1);
    chk({tag, ".rv_T"}, 32'(host_resp_valid), 32'd0);
    @(negedge clock);
    host_req_valid = 1'b0;
    if (fin_in_read) finish = 1'b1;
    #1;
    chk({tag, ".deq_T1"}, 32'(host_req_deq), 32'd0);
    if (op) begin
      chk({tag, ".rv_wr"}, 32'(host_resp_valid), 32'd0);
    end else begin
      chk({tag, ".rv"}, 32'(host_resp_valid), 32'd1);
      chk({tag, ".rd"}, host_resp_bits, exp_rd);
    end
  endtask

  task automatic wr(input logic [7:0] addr, input logic [31:0] val, input string tag);
    req(1'b1, addr, val, 32'd0, 1'b0, tag);
  endtask

  task automatic rd(input logic [7:0] addr, input logic [31:0] exp, input string tag);
    req(1'b0, addr, 32'd0, exp, 1'b0, tag);
  endtask

  // Launch write: launch must be high at T+2 only.
  task automatic wr_launch(input logic exp_launch, input string tag);
    wr(8'h00, 32'd1, tag);
    @(negedge clock);
    chk({tag, ".launch_T2"}, 32'(launch), 32'(exp_launch));
    @(negedge clock);
    chk({tag, ".launch_T3"}, 32'(launch), 32'd0);
  endtask

  task automatic chk_params(input logic [31:0] l, a, b, c, input string tag);
    chk({tag, ".length"}, length, l);
    chk({tag, ".a_addr"}, a_addr, a);
    chk({tag, ".b_addr"}, b_addr, b);
    chk({tag, ".c_addr"}, c_addr, c);
  endtask

  initial begin
    reset = 1'b1; host_req_valid = 1'b0; host_req_opcode = 1'b0;
    host_req_addr = '0; host_req_value = '0; finish = 1'b0;
    event_counter_valid = 1'b0; event_counter_value = '0;
    repeat (3) @(negedge clock);
    chk("rst.launch", 32'(launch), 32'd0);
    chk("rst.deq", 32'(host_req_deq), 32'd0);
    chk("rst.rv", 32'(host_resp_valid), 32'd0);
    chk("rst.rbits", host_resp_bits, 32'd0);
    chk_params(32'd0, 32'd0, 32'd0, 32'd0, "rst");
    reset = 1'b0;

    // All registers read 0 out of reset.
    rd(8'h00, 32'h0, "rd0.ctrl");
    rd(8'h04, 32'h0, "rd0.cycles");
    rd(8'h08, 32'h0, "rd0.length");
    rd(8'h0C, 32'h0, "rd0.a");
    rd(8'h10, 32'h0, "rd0.b");
    rd(8'h14, 32'h0, "rd0.c");

    // Parameter writes, visible on the ports at T+2.
    wr(8'h08, 32'h10, "wr.length");
    @(negedge clock); chk("port.length", length, 32'h10);
    wr(8'h0C, 32'h100, "wr.a");
    @(negedge clock); chk("port.a", a_addr, 32'h100);
    wr(8'h10, 32'h200, "wr.b");
    @(negedge clock); chk("port.b", b_addr, 32'h200);
    wr(8'h14, 32'h300, "wr.c");
    @(negedge clock); chk("port.c", c_addr, 32'h300);
    rd(8'h08, 32'h10, "rb.length");
    rd(8'h0C, 32'h100, "rb.a");
    rd(8'h10, 32'h200, "rb.b");
    rd(8'h14, 32'h300, "rb.c");

    // Launch, then launch/parameter writes while busy are dropped.
    wr_launch(1'b1, "launch1");
    rd(8'h00, 32'h4, "busy.ctrl");
    wr_launch(1'b0, "launch_busy");
    wr(8'h08, 32'h5, "wr.len_busy");
    rd(8'h08, 32'h10, "busy.length");
    chk("busy.port_len", length, 32'h10);

    // Finish with cycle count.
    @(negedge clock);
    finish = 1'b1; event_counter_valid = 1'b1; event_counter_value = 32'h2A;
    @(negedge clock);
    finish = 1'b0; event_counter_valid = 1'b0; event_counter_value = '0;
    rd(8'h00, 32'h2, "fin.ctrl");
    rd(8'h04, 32'h2A, "fin.cycles");

    // Relaunch clears finish and CYCLES.
    wr_launch(1'b1, "relaunch");
    rd(8'h00, 32'h4, "relaunch.ctrl");
    rd(8'h04, 32'h0, "relaunch.cycles");

    // Finish during a CTRL read is seen only by the next read.
    req(1'b0, 8'h00, 32'd0, 32'h4, 1'b1, "finrd.ctrl");
    @(negedge clock); finish = 1'b0;
    rd(8'h00, 32'h2, "finrd.after");

    // Unmapped and misaligned addresses.
    rd(8'h18, 32'h0, "unm.18");
    rd(8'h03, 32'h0, "unm.03");
    rd(8'hFC, 32'h0, "unm.FC");
    wr(8'h18, 32'hDEAD, "unm.wr18");
    @(negedge clock);
    chk_params(32'h10, 32'h100, 32'h200, 32'h300, "unm");
    rd(8'h00, 32'h2, "unm.ctrl");
    rd(8'h04, 32'h0, "unm.cycles");

    // Reset while busy, in the middle of a READ.
    wr_launch(1'b1, "launch3");
    @(negedge clock);
    host_req_valid = 1'b1; host_req_opcode = 1'b0; host_req_addr = 8'h00;
    #1 chk("rstrd.deq", 32'(host_req_deq), 32'd1);
    @(negedge clock);
    host_req_valid = 1'b0; reset = 1'b1;
    #1 chk("rstrd.rv", 32'(host_resp_valid), 32'd0);
    @(negedge clock);
    reset = 1'b0;
    chk("rstrd.rv2", 32'(host_resp_valid), 32'd0);
    chk_params(32'd0, 32'd0, 32'd0, 32'd0, "rstrd");
    rd(8'h00, 32'h0, "rstrd.ctrl");
    rd(8'h04, 32'h0, "rstrd.cycles");
    wr_launch(1'b1, "launch4");
    rd(8'h00, 32'h4, "launch4.ctrl");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
